// File: rtl/cpu_thermal_monitor.sv
// Temperature persistence filter with hysteresis, a sensor watchdog that fails safe,
// and a clearable peak-temperature register. Every output is registered, with a latency of 1.
module cpu_thermal_monitor #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned HI_THRESH    = 90,
   parameter int unsigned LO_THRESH    = 80,
   parameter int unsigned ASSERT_CNT   = 4,
   parameter int unsigned DEASSERT_CNT = 8,
   parameter int unsigned TIMEOUT      = 1000
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              temp_valid,
   input  logic [DATA_W-1:0] temp_data,
   input  logic              clear_max,
   output logic              cpu_overheated,
   output logic              sensor_fault,
   output logic [DATA_W-1:0] temp_max
);

   localparam int unsigned HW = $clog2(ASSERT_CNT + 1);
   localparam int unsigned CW = $clog2(DEASSERT_CNT + 1);
   localparam int unsigned IW = $clog2(TIMEOUT + 1);

   localparam logic [DATA_W-1:0] HI        = DATA_W'(HI_THRESH);
   localparam logic [DATA_W-1:0] LO        = DATA_W'(LO_THRESH);
   localparam logic [HW-1:0]     HOT_LAST  = HW'(ASSERT_CNT - 1);
   localparam logic [CW-1:0]     COOL_LAST = CW'(DEASSERT_CNT - 1);
   localparam logic [IW-1:0]     IDLE_LAST = IW'(TIMEOUT - 1);
   localparam logic [IW-1:0]     IDLE_SAT  = IW'(TIMEOUT);

   typedef enum logic [1:0] {COOL, HOT, FAULT} state_t;

   state_t          state;
   logic [HW-1:0]   hot_cnt;
   logic [CW-1:0]   cool_cnt;
   logic [IW-1:0]   idle_cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state          <= COOL;
         hot_cnt        <= '0;
         cool_cnt       <= '0;
         idle_cnt       <= '0;
         cpu_overheated <= 1'b0;
         sensor_fault   <= 1'b0;
         temp_max       <= '0;
      end else begin
         // A clear in the same cycle as a sample restarts the peak from that sample.
         if (clear_max || (temp_valid && temp_data > temp_max))
            temp_max <= temp_valid ? temp_data : '0;

         if (temp_valid) begin
            idle_cnt <= '0;
            case (state)
               COOL: begin
                  if (temp_data >= HI) begin
                     if (hot_cnt == HOT_LAST) begin
                        state          <= HOT;
                        hot_cnt        <= '0;
                        cpu_overheated <= 1'b1;
                     end else begin
                        hot_cnt <= hot_cnt + 1'b1;
                     end
                  end else begin
                     hot_cnt <= '0;
                  end
               end
               HOT: begin
                  if (temp_data <= LO) begin
                     if (cool_cnt == COOL_LAST) begin
                        state          <= COOL;
                        cool_cnt       <= '0;
                        cpu_overheated <= 1'b0;
                     end else begin
                        cool_cnt <= cool_cnt + 1'b1;
                     end
                  end else begin
                     cool_cnt <= '0;
                  end
               end
               // A recovered sensor stays fail-safe hot; its first sample does not start a cool run.
               FAULT: begin
                  state        <= HOT;
                  sensor_fault <= 1'b0;
               end
               default: begin
                  state          <= COOL;
                  cpu_overheated <= 1'b0;
                  sensor_fault   <= 1'b0;
               end
            endcase
         end else if (idle_cnt == IDLE_LAST) begin
            state          <= FAULT;
            hot_cnt        <= '0;
            cool_cnt       <= '0;
            idle_cnt       <= IDLE_SAT;
            cpu_overheated <= 1'b1;
            sensor_fault   <= 1'b1;
         end else if (idle_cnt != IDLE_SAT) begin
            idle_cnt <= idle_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cpu_thermal_monitor.sv
// Bench for cpu_thermal_monitor: every driven cycle pushes its expected outputs to a
// queue, and that entry is popped and compared once the edge has sampled the cycle.
module tb_cpu_thermal_monitor;

   logic       clk = 1'b0;
   logic       resetn;
   logic       temp_valid;
   logic [7:0] temp_data;
   logic       clear_max;
   logic       cpu_overheated;
   logic       sensor_fault;
   logic [7:0] temp_max;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       oh;
      logic       fault;
      logic [7:0] mx;
   } exp_t;
   exp_t exp_q[$];

   cpu_thermal_monitor #(
      .DATA_W(8), .HI_THRESH(90), .LO_THRESH(80),
      .ASSERT_CNT(4), .DEASSERT_CNT(8), .TIMEOUT(1000)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .temp_valid(temp_valid),
      .temp_data(temp_data),
      .clear_max(clear_max),
      .cpu_overheated(cpu_overheated),
      .sensor_fault(sensor_fault),
      .temp_max(temp_max)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Drive one cycle, queue its expected outputs, then compare just after the edge.
   task automatic step(input logic v, input logic [7:0] d, input logic c,
                       input logic oh, input logic f, input logic [7:0] mx, input string tag);
      exp_t e;
      temp_valid = v;
      temp_data  = d;
      clear_max  = c;
      e.oh = oh; e.fault = f; e.mx = mx;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_eq({tag, ".overheated"}, int'(cpu_overheated), int'(e.oh));
      check_eq({tag, ".fault"},      int'(sensor_fault),   int'(e.fault));
      check_eq({tag, ".max"},        int'(temp_max),       int'(e.mx));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      resetn = 1'b0; temp_valid = 1'b0; temp_data = '0; clear_max = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset.overheated", int'(cpu_overheated), 0);
      check_eq("reset.fault",      int'(sensor_fault),   0);
      check_eq("reset.max",        int'(temp_max),       0);
      resetn = 1'b1;

      // Four hot samples assert on the fourth.
      for (int i = 0; i < 4; i++) step(1, 8'd95, 0, (i == 3), 0, 8'd95, "assert4");

      // Cool run broken by a band sample; 80 closes the final run.
      for (int i = 0; i < 7; i++) step(1, 8'd70, 0, 1, 0, 8'd95, "cool7");
      step(1, 8'd85, 0, 1, 0, 8'd95, "band_hot");
      for (int i = 0; i < 7; i++) step(1, 8'd70, 0, 1, 0, 8'd95, "cool_run");
      step(1, 8'd80, 0, 0, 0, 8'd95, "cool_eq80");

      // Band sample breaks a hot run; 90 completes the next one.
      for (int i = 0; i < 3; i++) step(1, 8'd95, 0, 0, 0, 8'd95, "hot3a");
      step(1, 8'd85, 0, 0, 0, 8'd95, "band_cool");
      for (int i = 0; i < 3; i++) step(1, 8'd95, 0, 0, 0, 8'd95, "hot3b");
      step(1, 8'd90, 0, 1, 0, 8'd95, "hot_eq90");
      for (int i = 0; i < 8; i++) step(1, 8'd70, 0, (i != 7), 0, 8'd95, "deassert");

      // Idle gaps between hot samples do not break the run.
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 50; i++) step(0, 8'd0, 0, 0, 0, 8'd95, "gap_idle");
         step(1, 8'd95, 0, (k == 3), 0, 8'd95, "gap_hot");
      end
      for (int i = 0; i < 8; i++) step(1, 8'd70, 0, (i != 7), 0, 8'd95, "gap_deassert");

      // A sample on the expiring cycle prevents the fault.
      for (int i = 0; i < 999; i++) step(0, 8'd0, 0, 0, 0, 8'd95, "idle999");
      step(1, 8'd70, 0, 0, 0, 8'd95, "sample_saves");

      // A full timeout faults and holds while idle.
      for (int i = 0; i < 1000; i++)
         step(0, 8'd0, 0, (i == 999), (i == 999), 8'd95, "timeout");
      for (int i = 0; i < 20; i++) step(0, 8'd0, 0, 1, 1, 8'd95, "fault_hold");

      // Recovery goes to HOT and needs a full cool run.
      step(1, 8'd70, 0, 1, 0, 8'd95, "recover");
      for (int i = 0; i < 8; i++) step(1, 8'd70, 0, (i != 7), 0, 8'd95, "recover_cool");

      // Peak register clear behaviour.
      step(1, 8'd40, 1, 0, 0, 8'd40, "clear_with_valid");
      step(0, 8'd0, 1, 0, 0, 8'd0, "clear_alone");
      step(1, 8'd30, 0, 0, 0, 8'd30, "max_load");
      step(1, 8'd20, 0, 0, 0, 8'd30, "max_keep");

      // Reset mid hot run discards the partial count.
      for (int i = 0; i < 3; i++) step(1, 8'd95, 0, 0, 0, 8'd95, "prereset_hot");
      resetn = 1'b0;
      temp_valid = 1'b0;
      #2;
      check_eq("midreset.overheated", int'(cpu_overheated), 0);
      check_eq("midreset.fault",      int'(sensor_fault),   0);
      check_eq("midreset.max",        int'(temp_max),       0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) step(1, 8'd95, 0, (i == 3), 0, 8'd95, "restart_run");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
